adaptive_filter_mode_ctrl: RTL

- Sequencer placed in front of `adaptive_filter`. It owns the filter's `ctrl` (1 = integrator, 0 = differentiator) and `srst` inputs.
- It accepts mode-change requests, stalls the upstream sample stream, and waits for in-flight samples to leave the filter.
- It then resets the filter state, applies the new mode, and resumes streaming.
- Result: no output sample ever mixes state from both modes.

---
 rtl/adaptive_filter_mode_ctrl_if.sv | 36 +++
 rtl/adaptive_filter_mode_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/adaptive_filter_mode_ctrl_if.sv
// rtl/adaptive_filter_mode_ctrl_if.sv - request, sample-stream and filter-control bundle for adaptive_filter_mode_ctrl
//
// master: requester / upstream source / filter side (drives requests, samples, f_m_tvalid)
// slave : adaptive_filter_mode_ctrl (drives ready, filter-side stream, srst, ctrl, busy)
//   mode_req_valid, mode_req, mode_req_ready : mode-change request handshake
//   s_tdata, s_tvalid, s_tready              : upstream sample stream
//   f_tdata, f_tvalid                        : sample stream into the filter
//   f_m_tvalid                               : filter output valid, for in-flight tracking
//   f_srst, f_ctrl                           : filter synchronous reset and mode select
//   busy                                     : controller not streaming
interface adaptive_filter_mode_ctrl_if #(
    parameter int WORDLENGTH = 14
);
    logic                  mode_req_valid;
    logic                  mode_req;
    logic                  mode_req_ready;
    logic [WORDLENGTH-1:0] s_tdata;
    logic                  s_tvalid;
    logic                  s_tready;
    logic [WORDLENGTH-1:0] f_tdata;
    logic                  f_tvalid;
    logic                  f_m_tvalid;
    logic                  f_srst;
    logic                  f_ctrl;
    logic                  busy;

    modport master (
        output mode_req_valid, mode_req, s_tdata, s_tvalid, f_m_tvalid,
        input  mode_req_ready, s_tready, f_tdata, f_tvalid, f_srst, f_ctrl, busy
    );

    modport slave (
        input  mode_req_valid, mode_req, s_tdata, s_tvalid, f_m_tvalid,
        output mode_req_ready, s_tready, f_tdata, f_tvalid, f_srst, f_ctrl, busy
    );
endinterface

// File: rtl/adaptive_filter_mode_ctrl.sv
// rtl/adaptive_filter_mode_ctrl.sv - mode-switch sequencer (drain, flush, settle) in front of adaptive_filter
//
// Ports:
//   clk     : clock
//   arst_n  : asynchronous active-low reset
//   bus     : adaptive_filter_mode_ctrl_if.slave (request handshake, upstream stream,
//             filter-side stream, f_m_tvalid, f_srst, f_ctrl, busy)
// Optional (macro ADAPTIVE_FILTER_MODE_CTRL_STATS_EN):
//   switch_cnt[15:0]  : number of DRAIN entries, wrapping
//   timeout_flag[0:0] : sticky, a DRAIN ended by timeout
module adaptive_filter_mode_ctrl #(
    parameter int   WORDLENGTH     = 14,
    parameter int   FILTER_LATENCY = 2,
    parameter int   FLUSH_CYCLES   = 2,
    parameter int   DRAIN_TIMEOUT  = 16,
    parameter logic INIT_MODE      = 1'b0
) (
    input  logic                        clk,
    input  logic                        arst_n,
    adaptive_filter_mode_ctrl_if.slave  bus
`ifdef ADAPTIVE_FILTER_MODE_CTRL_STATS_EN
    ,
    output logic [15:0]                 switch_cnt,
    output logic [0:0]                  timeout_flag
`endif
);

    localparam int IW = $clog2(FILTER_LATENCY + 2);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int DW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);
    localparam logic [IW-1:0] INF_MAX    = '1;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_SETTLE = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [FW-1:0] flush_cnt;
    logic [DW-1:0] drain_cnt;
    logic [IW-1:0] inflight;
    logic [IW-1:0] inflight_nxt;
    logic          pending;
    logic          ctrl_q;
    logic          in_run;
    logic          do_switch;
    logic          drain_done;
    logic          drain_tmo;

    assign in_run             = (state == ST_RUN);
    assign bus.mode_req_ready = in_run;
    // A pending request wins over the stream, so the input stalls for that cycle.
    assign bus.s_tready       = in_run & ~bus.mode_req_valid;
    assign bus.f_tdata        = bus.s_tdata[WORDLENGTH-1:0];
    assign bus.f_tvalid       = bus.s_tvalid & bus.s_tready;
    assign bus.f_srst         = (state == ST_FLUSH);
    // The new mode is presented while the filter is held in reset so it
    // restarts cleanly in that mode.
    assign bus.f_ctrl         = (state == ST_FLUSH) ? pending : ctrl_q;
    assign bus.busy           = ~in_run;

    assign do_switch  = in_run & bus.mode_req_valid & (bus.mode_req != ctrl_q);
    assign drain_done = (inflight_nxt == '0);
    assign drain_tmo  = (drain_cnt == DRAIN_LAST);

    // Saturating in-flight count; a simultaneous enter and leave cancel out.
    always_comb begin
        inflight_nxt = inflight;
        if (bus.f_tvalid && !bus.f_m_tvalid && inflight != INF_MAX) begin
            inflight_nxt = inflight + 1'b1;
        end else if (!bus.f_tvalid && bus.f_m_tvalid && inflight != '0) begin
            inflight_nxt = inflight - 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (do_switch) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (drain_done || drain_tmo) state_nxt = ST_FLUSH;
            ST_FLUSH:  if (flush_cnt == FLUSH_LAST) state_nxt = ST_SETTLE;
            ST_SETTLE: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
            drain_cnt <= '0;
            inflight  <= '0;
            pending   <= INIT_MODE;
            ctrl_q    <= INIT_MODE;
        end else begin
            state     <= state_nxt;
            // Anything still inside the filter is discarded by the flush.
            inflight  <= (state == ST_FLUSH) ? '0 : inflight_nxt;
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
            flush_cnt <= (state == ST_FLUSH && flush_cnt != FLUSH_LAST) ? flush_cnt + 1'b1 : '0;
            if (do_switch) begin
                pending <= bus.mode_req;
            end
            if (state == ST_FLUSH) begin
                ctrl_q <= pending;
            end
        end
    end

`ifdef ADAPTIVE_FILTER_MODE_CTRL_STATS_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            switch_cnt   <= '0;
            timeout_flag <= '0;
        end else begin
            if (do_switch) begin
                switch_cnt <= switch_cnt + 16'd1;
            end
            // Draining to zero on the last allowed cycle counts as a clean exit.
            if (state == ST_DRAIN && drain_tmo && !drain_done) begin
                timeout_flag <= 1'b1;
            end
        end
    end
`endif

endmodule
